// File: rtl/seg_capture_decoder_pkg.sv
// seg_capture_pkg: character codes, FSM state encoding, 7-segment glyph
// patterns and small digit-enable helpers shared by the capture decoder
// and the display drivers.
package seg_capture_pkg;

    // Character codes carried on the output stream
    localparam logic [4:0] CH_BLANK   = 5'h00;
    localparam logic [4:0] CH_U       = 5'h01;
    localparam logic [4:0] CH_A       = 5'h02;
    localparam logic [4:0] CH_B       = 5'h03;
    localparam logic [4:0] CH_C       = 5'h04;
    localparam logic [4:0] CH_DASH    = 5'h05;
    localparam logic [4:0] CH_E       = 5'h06;
    localparam logic [4:0] CH_L       = 5'h07;
    localparam logic [4:0] CH_T       = 5'h08;
    localparam logic [4:0] CH_R       = 5'h09;
    localparam logic [4:0] CH_O       = 5'h0A;
    localparam logic [4:0] CH_N       = 5'h0B;
    localparam logic [4:0] CH_I       = 5'h0C;
    localparam logic [4:0] CH_UNKNOWN = 5'h1F;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_U     = 7'b1000001;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_L     = 7'b1000111;
    localparam logic [6:0] GLYPH_T     = 7'b1001110;
    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_O     = 7'b1000000;
    localparam logic [6:0] GLYPH_N     = 7'b0101011;
    localparam logic [6:0] GLYPH_I     = 7'b1001111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_HOLD   = 2'd3
    } cap_state_e;

    // True when exactly one active-low digit enable is asserted
    function automatic logic an_single_low(input logic [3:0] a);
        case (a)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // True when two or more digit enables are asserted together
    function automatic logic an_multi_low(input logic [3:0] a);
        return (a != 4'b1111) && !an_single_low(a);
    endfunction

    // Digit index of the single low enable; only meaningful when an_single_low
    function automatic logic [1:0] an_index(input logic [3:0] a);
        case (a)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg_capture_decoder_if.sv
// Character output stream of the capture decoder: code/digit with a
// valid/ready handshake. master = producer (decoder), slave = consumer.
interface seg_capture_decoder_if;
    logic [4:0] char_code;
    logic [1:0] char_digit;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_code,
        output char_digit,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_code,
        input  char_digit,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: purely combinational active-low 7-segment pattern to
// character code lookup. Unrecognised patterns map to CH_UNKNOWN.
module seg_glyph_decode
    import seg_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [4:0] code
);

    // Table lookup; anything not in the glyph set is reported as unknown
    always_comb begin
        code = CH_UNKNOWN;
        case (pattern)
            GLYPH_BLANK: code = CH_BLANK;
            GLYPH_U:     code = CH_U;
            GLYPH_A:     code = CH_A;
            GLYPH_B:     code = CH_B;
            GLYPH_C:     code = CH_C;
            GLYPH_DASH:  code = CH_DASH;
            GLYPH_E:     code = CH_E;
            GLYPH_L:     code = CH_L;
            GLYPH_T:     code = CH_T;
            GLYPH_R:     code = CH_R;
            GLYPH_O:     code = CH_O;
            GLYPH_N:     code = CH_N;
            GLYPH_I:     code = CH_I;
            default:     code = CH_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder: samples an asynchronous active-low seg/an display
// bus, waits for a glyph to be stable for STABLE_CYC synchronised samples,
// decodes it and emits one character per displayed glyph on a valid/ready
// stream. Optional macro SEG_CAPTURE_ERRCNT_EN adds an 8-bit saturating
// error counter output (unknown glyphs, multiple digits enabled).
module seg_capture_decoder
    import seg_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [3:0]            an,
    seg_capture_decoder_if.master char_if,
    output logic                  disp_active,
`ifdef SEG_CAPTURE_ERRCNT_EN
    output logic [7:0]            err_cnt,
`endif
    output logic                  ovf
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int SMP_W = 11;

    // Synchroniser chain for {an, seg}; idles at all-ones (display dark)
    logic [SYNC_STAGES-1:0][SMP_W-1:0] sync_q, sync_d;

    logic [SMP_W-1:0] sample;
    logic             smp_valid;

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SMP_W-1:0] tag_q, tag_d;
    logic [SMP_W-1:0] last_tag_q, last_tag_d;
    logic             last_vld_q, last_vld_d;
    logic [4:0]       code_q, code_d;
    logic [1:0]       digit_q, digit_d;
    logic             valid_q, valid_d;
    logic             disp_active_q, disp_active_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       dec_code;

`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             err_inc;
`endif

    // Shift the raw pins through the synchroniser
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {an, seg};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sample    = sync_q[SYNC_STAGES-1];
    assign smp_valid = an_single_low(sample[10:7]);

    // The qualified glyph is the segment half of the held tag
    seg_glyph_decode u_glyph_decode (
        .pattern (tag_q[6:0]),
        .code    (dec_code)
    );

    // Next-state: stability qualification, emit decision and output register
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        last_tag_d    = last_tag_q;
        last_vld_d    = last_vld_q;
        code_d        = code_q;
        digit_d       = digit_q;
        valid_d       = valid_q;
        ovf_d         = ovf_q;
        disp_active_d = smp_valid;
`ifdef SEG_CAPTURE_ERRCNT_EN
        err_inc       = 1'b0;
`endif

        // Consumer handshake frees the output; EMIT below may refill it
        if (valid_q && char_if.char_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (smp_valid) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                    tag_d   = sample;
                end
            end

            ST_SETTLE: begin
                if (!smp_valid) begin
                    // Display blanked or ambiguous: forget the last glyph
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    last_vld_d = 1'b0;
`ifdef SEG_CAPTURE_ERRCNT_EN
                    err_inc    = an_multi_low(sample[10:7]);
`endif
                end else if (sample == tag_q) begin
                    if (cnt_q < CNT_W'(STABLE_CYC - 1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        // Qualified; suppress a repeat of what was just shown
                        cnt_d   = CNT_W'(STABLE_CYC);
                        state_d = (last_vld_q && (last_tag_q == tag_q)) ? ST_HOLD : ST_EMIT;
                    end
                end else begin
                    // Still changing: re-arm on the new sample
                    cnt_d = CNT_W'(1);
                    tag_d = sample;
                end
            end

            ST_EMIT: begin
                if (!valid_q || char_if.char_ready) begin
                    code_d  = dec_code;
                    digit_d = an_index(tag_q[10:7]);
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                last_tag_d = tag_q;
                last_vld_d = 1'b1;
                state_d    = ST_HOLD;
`ifdef SEG_CAPTURE_ERRCNT_EN
                err_inc    = (dec_code == CH_UNKNOWN);
`endif
            end

            ST_HOLD: begin
                if (!smp_valid) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    last_vld_d = 1'b0;
`ifdef SEG_CAPTURE_ERRCNT_EN
                    err_inc    = an_multi_low(sample[10:7]);
`endif
                end else if (sample != tag_q) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                    tag_d   = sample;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, stability counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tag_q         <= '1;
            last_tag_q    <= '1;
            last_vld_q    <= 1'b0;
            code_q        <= '0;
            digit_q       <= '0;
            valid_q       <= 1'b0;
            disp_active_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tag_q         <= tag_d;
            last_tag_q    <= last_tag_d;
            last_vld_q    <= last_vld_d;
            code_q        <= code_d;
            digit_q       <= digit_d;
            valid_q       <= valid_d;
            disp_active_q <= disp_active_d;
            ovf_q         <= ovf_d;
        end
    end

`ifdef SEG_CAPTURE_ERRCNT_EN
    // Saturating error count
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign char_if.char_code  = code_q;
    assign char_if.char_digit = digit_q;
    assign char_if.char_valid = valid_q;
    assign disp_active        = disp_active_q;
    assign ovf                = ovf_q;

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Scoreboard bench for seg_capture_decoder: a cycle-level reference model
// (run-length of identical synchronised samples, one-entry output buffer)
// pushes expected characters; a negedge monitor pops them on handshakes.
module tb_seg_capture_decoder;
    localparam int SYNC = 2;
    localparam int STAB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic [3:0] an;
    logic       disp_active;
    logic       ovf;
`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    seg_capture_decoder_if cif();

    seg_capture_decoder #(.SYNC_STAGES(SYNC), .STABLE_CYC(STAB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .char_if     (cif),
        .disp_active (disp_active),
`ifdef SEG_CAPTURE_ERRCNT_EN
        .err_cnt     (err_cnt),
`endif
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    // Glyph table written from the character list; code == table index
    localparam logic [6:0] PATS [13] = '{
        7'b1111111, 7'b1000001, 7'b0001000, 7'b0000011, 7'b1000110,
        7'b0111111, 7'b0000110, 7'b1000111, 7'b1001110, 7'b0101111,
        7'b1000000, 7'b0101011, 7'b1001111 };

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [4:0] code; logic [1:0] digit; } exp_t;
    exp_t expq[$];

    // Reference model state
    logic [10:0] msync [SYNC];
    logic [10:0] mprev, last_tag, pend_tag;
    int          run, merr;
    logic        last_none, mvalid, movf, mdisp, emit_pend;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_code(input logic [6:0] p);
        for (int i = 0; i < 13; i++) if (p == PATS[i]) return 5'(i);
        return 5'h1F;
    endfunction

    function automatic int zeros(input logic [3:0] a);
        int z = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) z++;
        return z;
    endfunction

    function automatic logic [1:0] ref_digit(input logic [3:0] a);
        for (int i = 0; i < 4; i++) if (!a[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) msync[i] = '1;
        mprev = '1; last_tag = '1; pend_tag = '1;
        run = 0; merr = 0; last_none = 1'b1;
        mvalid = 1'b0; movf = 1'b0; mdisp = 1'b0; emit_pend = 1'b0;
        expq.delete();
    endtask

    // One clock of the reference model, using the inputs held across the edge
    task automatic model_step(input logic [6:0] s, input logic [3:0] a, input logic r);
        logic [10:0] smp;
        logic [4:0]  c;
        logic        nv;
        int          z;
        smp = msync[SYNC-1];
        for (int i = SYNC-1; i > 0; i--) msync[i] = msync[i-1];
        msync[0] = {a, s};
        nv = mvalid && !r;
        if (emit_pend) begin
            c = ref_code(pend_tag[6:0]);
            if (c == 5'h1F && merr < 255) merr++;
            if (!mvalid || r) begin
                expq.push_back({c, ref_digit(pend_tag[10:7])});
                nv = 1'b1;
            end else begin
                movf = 1'b1;
            end
            emit_pend = 1'b0;
        end
        mvalid = nv;
        z = zeros(smp[10:7]);
        mdisp = (z == 1);
        if (z != 1) begin
            if (run > 0 && z > 1 && merr < 255) merr++;
            run = 0;
            last_none = 1'b1;
        end else if (run > 0 && smp == mprev) begin
            if (run < STAB) begin
                run++;
                if (run == STAB && (last_none || smp != last_tag)) begin
                    emit_pend = 1'b1;
                    pend_tag  = smp;
                    last_tag  = smp;
                    last_none = 1'b0;
                end
            end
        end else begin
            run = 1;
        end
        mprev = smp;
    endtask

    task automatic cycle(input logic [6:0] s, input logic [3:0] a, input logic r);
        seg = s; an = a; cif.char_ready = r;
        @(posedge clk); #1;
        model_step(s, a, r);
        chk("char_valid", cif.char_valid, mvalid);
        chk("disp_active", disp_active, mdisp);
        chk("ovf", ovf, movf);
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] a, input logic r, input int n);
        for (int i = 0; i < n; i++) cycle(s, a, r);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            seg = 7'($urandom); an = 4'($urandom); cif.char_ready = 1'($urandom);
            @(posedge clk); #1;
            model_reset();
        end
        rst_n = 1'b1;
    endtask

    // Monitor: pop and compare on every handshake; check data stability while stalled
    logic       hold_v = 1'b0;
    logic [6:0] hold_cd;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v && cif.char_valid)
                chk("stall_stable", {cif.char_code, cif.char_digit}, hold_cd);
            if (cif.char_valid && cif.char_ready) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_char got %0h exp none", cif.char_code);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("char_code", cif.char_code, e.code);
                    chk("char_digit", cif.char_digit, e.digit);
                end
            end
            hold_v  <= cif.char_valid && !cif.char_ready;
            hold_cd <= {cif.char_code, cif.char_digit};
        end
    end

    initial begin
        int lat;
        logic [6:0] s;
        logic [3:0] a;
        logic [6:0] ps;
        logic [3:0] pa;
        logic [3:0] multi [4];
        multi = '{4'b1100, 4'b0011, 4'b1010, 4'b0000};

        // Reset with arbitrary pins
        do_reset(3);
        chk("rst_code", cif.char_code, 5'h00);
        chk("rst_digit", cif.char_digit, 2'd0);
        chk("rst_valid", cif.char_valid, 1'b0);
        chk("rst_disp", disp_active, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        hold(7'h7F, 4'b1111, 1'b1, 10);

        // Single glyph: latency and no repeat
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(7'b1000001, 4'b1110, 1'b1);
            if (lat == 0 && cif.char_valid) lat = i;
        end
        chk("latency", lat, 19);

        // Scroll sequence after a blank gap
        hold(7'h7F, 4'b1111, 1'b1, 5);
        for (int i = 1; i <= 7; i++) hold(PATS[i], 4'b1110, 1'b1, 20);

        // Glitching segments, then a steady A
        for (int i = 0; i < 12; i++) hold((i % 2) ? PATS[3] : PATS[2], 4'b1110, 1'b1, 5);
        hold(PATS[2], 4'b1110, 1'b1, 30);

        // Stalled consumer: E held in output, L dropped
        hold(PATS[6], 4'b1101, 1'b0, 25);
        hold(PATS[7], 4'b1101, 1'b0, 25);
        chk("ovf_set", ovf, 1'b1);
        chk("code_held", cif.char_code, 5'h06);
        hold(PATS[7], 4'b1101, 1'b1, 5);

        // Unknown glyph, then two digits enabled at once
        hold(7'b0110110, 4'b1110, 1'b1, 25);
        hold(7'b0110110, 4'b1100, 1'b1, 30);
`ifdef SEG_CAPTURE_ERRCNT_EN
        chk("err_cnt", err_cnt, 8'd2);
`endif

        // Reset in the middle of settling: nothing may come out afterwards
        hold(PATS[10], 4'b0111, 1'b1, 10);
        do_reset(2);
        hold(7'h7F, 4'b1111, 1'b1, 30);

        // Randomised glyph segments with random consumer back-pressure
        ps = 7'h7F; pa = 4'b1111;
        for (int k = 0; k < 80; k++) begin
            int sel, len;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                a = 4'b1111; s = 7'($urandom);
            end else if (sel == 1) begin
                a = multi[$urandom_range(0, 3)]; s = 7'($urandom);
            end else begin
                a = ~(4'b0001 << $urandom_range(0, 3));
                s = ($urandom_range(0, 7) == 0) ? 7'($urandom) : PATS[$urandom_range(0, 12)];
            end
            if ({a, s} == {pa, ps}) s = s ^ 7'h01;
            len = $urandom_range(0, 1) ? $urandom_range(20, 35) : $urandom_range(1, 12);
            for (int i = 0; i < len; i++) cycle(s, a, ($urandom_range(0, 9) < 7));
            ps = s; pa = a;
        end

        // Drain
        hold(7'h7F, 4'b1111, 1'b1, 10);
        chk("queue_empty", expq.size(), 0);
`ifdef SEG_CAPTURE_ERRCNT_EN
        chk("err_cnt_final", err_cnt, merr);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
